// File: rtl/pic_pkg.sv
// Shared constants and priority arithmetic for the 8259-style interrupt priority resolver.
package pic_pkg;

  localparam int NUM_IR = 8;
  localparam int IR_W = 3;
  localparam logic [IR_W-1:0] LOWEST_PRIO_RESET = 3'd7;

  // IR index visited at step k (0 = highest priority) of the cyclic search after lowest_prio.
  function automatic logic [IR_W-1:0] rot_index(input logic [IR_W-1:0] lowest_prio, input int k);
    return lowest_prio + 3'(k) + 3'd1;
  endfunction

  // Position of an IR in the current priority order: 0 is highest, 7 is lowest_prio itself.
  function automatic logic [IR_W-1:0] prio_rank(input logic [IR_W-1:0] idx, input logic [IR_W-1:0] lowest_prio);
    return idx - lowest_prio - 3'd1;
  endfunction

endpackage

// File: rtl/rot_priority_encoder.sv
// Combinational find-first over an 8-bit vector, scanning cyclically from the IR just above lowest_prio.
module rot_priority_encoder
  import pic_pkg::*;
(
  input  logic [NUM_IR-1:0] vec,
  input  logic [IR_W-1:0]   lowest_prio,
  output logic [IR_W-1:0]   idx,
  output logic              found
);

  always_comb begin
    idx = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_IR; k++) begin
      if (!found && vec[rot_index(lowest_prio, k)]) begin
        found = 1'b1;
        idx = rot_index(lowest_prio, k);
      end
    end
  end

endmodule

// File: rtl/priority_resolver.sv
// Selects the highest-priority unmasked request that may preempt the in-service set; owns ISR and rotation pointer.
module priority_resolver
  import pic_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_IR-1:0] IRR,
  input  logic [NUM_IR-1:0] IMR,
  input  logic              auto_rotate,
  input  logic              int_ack,
  input  logic              eoi,
  output logic [IR_W-1:0]   chosen_interrupt,
  output logic              int_valid,
  output logic [NUM_IR-1:0] ISR
);

  logic [IR_W-1:0]   lowest_prio;
  logic [NUM_IR-1:0] pending;
  logic [NUM_IR-1:0] isr_next;
  logic [IR_W-1:0]   req_idx;
  logic [IR_W-1:0]   isr_idx;
  logic              req_found;
  logic              isr_found;
  logic              req_valid;
  logic              eoi_hit;

  assign pending = IRR & ~IMR;

  rot_priority_encoder u_req_enc (
    .vec         (pending),
    .lowest_prio (lowest_prio),
    .idx         (req_idx),
    .found       (req_found)
  );

  rot_priority_encoder u_isr_enc (
    .vec         (ISR),
    .lowest_prio (lowest_prio),
    .idx         (isr_idx),
    .found       (isr_found)
  );

  // A request at the same level as the top in-service bit must not re-enter.
  assign req_valid = req_found &&
                     (!isr_found || (prio_rank(req_idx, lowest_prio) < prio_rank(isr_idx, lowest_prio)));

  assign eoi_hit = eoi && isr_found;

  // Clear before set so a same-cycle ack of the bit being retired keeps it in service.
  always_comb begin
    isr_next = ISR;
    if (eoi_hit) isr_next[isr_idx] = 1'b0;
    if (int_ack && int_valid) isr_next[chosen_interrupt] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chosen_interrupt <= '0;
      int_valid        <= 1'b0;
      ISR              <= '0;
      lowest_prio      <= LOWEST_PRIO_RESET;
    end else begin
      chosen_interrupt <= req_valid ? req_idx : '0;
      int_valid        <= req_valid;
      ISR              <= isr_next;
      if (eoi_hit && auto_rotate) lowest_prio <= isr_idx;
    end
  end

endmodule

// File: tb/tb_priority_resolver.sv
// Directed plus randomized checks of priority_resolver against a rank-based reference model.
module tb_priority_resolver;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] IRR, IMR;
  logic       auto_rotate, int_ack, eoi;
  logic [2:0] chosen_interrupt;
  logic       int_valid;
  logic [7:0] ISR;

  int compared = 0;
  int mismatched = 0;

  // Reference state: registered outputs, in-service set and lowest-priority IR.
  int       m_chosen;
  bit       m_valid;
  bit [7:0] m_isr;
  int       m_lp;

  priority_resolver dut (
    .clk              (clk),
    .reset            (reset),
    .IRR              (IRR),
    .IMR              (IMR),
    .auto_rotate      (auto_rotate),
    .int_ack          (int_ack),
    .eoi              (eoi),
    .chosen_interrupt (chosen_interrupt),
    .int_valid        (int_valid),
    .ISR              (ISR)
  );

  always #5 clk = ~clk;

  function automatic int rank(int i, int lp);
    return (i - lp + 7) % 8;
  endfunction

  // Best (lowest-rank) set bit of v, or -1 when empty.
  function automatic int best_of(bit [7:0] v, int lp);
    int b = -1;
    for (int i = 0; i < 8; i++)
      if (v[i] && (b < 0 || rank(i, lp) < rank(b, lp))) b = i;
    return b;
  endfunction

  task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_chosen = 0;
    m_valid = 0;
    m_isr = '0;
    m_lp = 7;
  endtask

  // One clock: evaluate the model from pre-edge state, clock the DUT, compare all outputs.
  task automatic tick(string tag);
    int cand, top, n_chosen, n_lp;
    bit n_valid;
    bit [7:0] n_isr;
    cand = best_of(IRR & ~IMR, m_lp);
    top = best_of(m_isr, m_lp);
    n_valid = (cand >= 0) && (top < 0 || rank(cand, m_lp) < rank(top, m_lp));
    n_chosen = n_valid ? cand : 0;
    n_isr = m_isr;
    n_lp = m_lp;
    if (eoi && top >= 0) begin
      n_isr[top] = 1'b0;
      if (auto_rotate) n_lp = top;
    end
    if (int_ack && m_valid) n_isr[m_chosen] = 1'b1;
    @(posedge clk);
    #1;
    m_chosen = n_chosen;
    m_valid = n_valid;
    m_isr = n_isr;
    m_lp = n_lp;
    check({tag, ".chosen"}, 8'(chosen_interrupt), 8'(m_chosen));
    check({tag, ".valid"}, 8'(int_valid), 8'(m_valid));
    check({tag, ".isr"}, ISR, m_isr);
  endtask

  initial begin
    reset = 1'b1;
    IRR = '0; IMR = '0; auto_rotate = 1'b0; int_ack = 1'b0; eoi = 1'b0;
    model_reset();
    #12;
    check("reset.chosen", 8'(chosen_interrupt), 8'd0);
    check("reset.valid", 8'(int_valid), 8'd0);
    check("reset.isr", ISR, 8'd0);
    @(negedge clk);
    reset = 1'b0;

    IRR = 8'b0110_0000;
    tick("fn0");
    check("fn0.is5", 8'(chosen_interrupt), 8'd5);
    IRR = 8'b0001_0000; tick("fn1"); check("fn1.is4", 8'(chosen_interrupt), 8'd4);
    IRR = 8'b0000_1000; tick("fn2"); check("fn2.is3", 8'(chosen_interrupt), 8'd3);
    IRR = 8'b0000_0100; tick("fn3"); check("fn3.is2", 8'(chosen_interrupt), 8'd2);
    IRR = 8'b0000_0001; tick("fn4"); check("fn4.is0", 8'(chosen_interrupt), 8'd0);
    IRR = 8'b0000_0000; tick("idle"); check("idle.valid0", 8'(int_valid), 8'd0);

    IRR = 8'b0000_0011; IMR = 8'b0000_0001;
    tick("mask"); check("mask.is1", 8'(chosen_interrupt), 8'd1);
    int_ack = 1'b1; tick("ack1"); int_ack = 1'b0;
    check("ack1.isr", ISR, 8'b0000_0010);
    tick("self_block"); check("self_block.valid0", 8'(int_valid), 8'd0);
    IMR = 8'b0000_0000;
    tick("preempt"); check("preempt.is0", 8'(chosen_interrupt), 8'd0);
    check("preempt.valid1", 8'(int_valid), 8'd1);
    IRR = 8'b0000_0000;
    eoi = 1'b1; tick("eoi_fn"); eoi = 1'b0;

    auto_rotate = 1'b1; IRR = 8'b0110_0000;
    tick("rot0"); check("rot0.is5", 8'(chosen_interrupt), 8'd5);
    int_ack = 1'b1; tick("rot_ack"); int_ack = 1'b0;
    eoi = 1'b1; tick("rot_eoi"); eoi = 1'b0;
    check("rot_eoi.isr0", ISR, 8'd0);
    tick("rot1"); check("rot1.is6", 8'(chosen_interrupt), 8'd6);
    IRR = 8'b0000_0010;
    tick("rot2"); check("rot2.is1", 8'(chosen_interrupt), 8'd1);

    IRR = 8'b0000_0100; tick("both0");
    int_ack = 1'b1; tick("both1"); int_ack = 1'b0;
    IRR = 8'b0000_0010; tick("both2");
    check("both2.is1", 8'(chosen_interrupt), 8'd1);
    int_ack = 1'b1; eoi = 1'b1; tick("both3"); int_ack = 1'b0; eoi = 1'b0;
    check("both3.isr", ISR, 8'b0000_0010);

    #3 reset = 1'b1;
    model_reset();
    #1;
    check("areset.isr", ISR, 8'd0);
    check("areset.valid", 8'(int_valid), 8'd0);
    check("areset.chosen", 8'(chosen_interrupt), 8'd0);
    @(negedge clk);
    reset = 1'b0;
    IRR = 8'b1000_0001;
    tick("post_reset"); check("post_reset.is0", 8'(chosen_interrupt), 8'd0);

    for (int n = 0; n < 400; n++) begin
      IRR = 8'($urandom);
      IMR = 8'($urandom) & 8'($urandom);
      if ($urandom_range(0, 15) == 0) auto_rotate = ~auto_rotate;
      int_ack = ($urandom_range(0, 9) < 3);
      eoi = ($urandom_range(0, 9) < 2);
      tick("rand");
    end
    int_ack = 1'b0; eoi = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
